// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and types for the fetch/execute sequencer.
// Holds the FSM state enum, opcode/offset field positions and widths.
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 23;
  localparam int DATA_W      = 24;
  localparam int REG_IDX_W   = 2;

  localparam int OPC_W  = 5;
  localparam int OPC_HI = 22;
  localparam int OPC_LO = 18;
  localparam int OFF_HI = 11;
  localparam int OFF_LO = 0;

  localparam logic [OPC_W-1:0] HALT_OP_DEF = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, mem, wb.
// Ports: clock/reset (sync, active-high), start; imem_req/addr/valid/data;
// instr (IR); is_mem/is_branch/alu_zero from decode/ALU; dmem_req/ack;
// alu_en/wb_en strobes; halted; pc.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int               ADDR_W  = ADDR_W_DEF,
  parameter int               INSTR_W = INSTR_W_DEF,
  parameter logic [OPC_W-1:0] HALT_OP = HALT_OP_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  input  logic               is_mem,
  input  logic               is_branch,
  input  logic               alu_zero,
  output logic               dmem_req,
  input  logic               dmem_ack,
  output logic               alu_en,
  output logic               wb_en,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc
);

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] ir_nxt;

  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_br;

  // Signed size cast sign-extends the 12-bit branch offset.
  assign off_ext = ADDR_W'($signed(ir_q[OFF_HI:OFF_LO]));
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign pc_br   = pc_inc + off_ext;

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = ir_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      pc_q  <= '0;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ir_q  <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    imem_req  = 1'b0;
    alu_en    = 1'b0;
    dmem_req  = 1'b0;
    wb_en     = 1'b0;
    halted    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_nxt    = imem_data;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[OPC_HI:OPC_LO] == HALT_OP)
          state_nxt = S_HALT;
        else
          state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        // Memory ops win over a stray branch decode.
        if (is_mem) begin
          state_nxt = S_MEM;
        end else if (is_branch) begin
          state_nxt = S_FETCH;
          pc_nxt    = alu_zero ? pc_inc : pc_br;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack)
          state_nxt = S_WB;
      end
      S_WB: begin
        wb_en     = 1'b1;
        pc_nxt    = pc_inc;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 12, as the PC and instruction-address width.
REQ-002 The block SHALL take parameter INSTR_W, default 23, as the instruction width.
REQ-003 The block SHALL take parameter HALT_OP, default 5'b11111, as the opcode that halts sequencing.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: leave IDLE and begin fetching at PC 0.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction read request.
REQ-008 The block SHALL have port imem_addr, output, ADDR_W bits: fetch address, equal to pc.
REQ-009 The block SHALL have port imem_valid, input, 1 bit: imem_data is valid this cycle.
REQ-010 The block SHALL have port imem_data, input, INSTR_W bits: fetched instruction, with opcode [22:18] and offset [11:0].
REQ-011 The block SHALL have port instr, output, INSTR_W bits: the held instruction register (IR).
REQ-012 The block SHALL have port is_mem, input, 1 bit: decoded memRead or memWrite for IR.
REQ-013 The block SHALL have port is_branch, input, 1 bit: decoded PCSrc for IR.
REQ-014 The block SHALL have port alu_zero, input, 1 bit: ALU zero flag, sampled in EXECUTE.
REQ-015 The block SHALL have ports dmem_req (output, 1 bit) and dmem_ack (input, 1 bit): the data-memory handshake.
REQ-016 The block SHALL have ports alu_en, wb_en and halted: outputs, 1 bit each: execute strobe, register-write strobe and halt indicator.
REQ-017 The block SHALL have port pc, output, ADDR_W bits: the program counter.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE, MEM, WB and HALT.
REQ-019 In IDLE, start=1 SHALL clear pc to 0 and enter FETCH; start is ignored in every other state.
REQ-020 In FETCH, imem_req SHALL be 1; on imem_valid=1 the block SHALL load imem_data into IR and enter DECODE; otherwise it SHALL hold (no timeout).
REQ-021 DECODE SHALL last 1 cycle; it SHALL go to HALT if IR[22:18]==HALT_OP, and to EXECUTE otherwise.
REQ-022 EXECUTE SHALL last 1 cycle with alu_en=1; the next state SHALL be MEM if is_mem=1, else FETCH if is_branch=1, else WB.
REQ-023 For a branch, the block SHALL set pc to pc+1+signext(IR[11:0]) mod 2^ADDR_W when alu_zero=0 (branch-if-not-equal), and to pc+1 otherwise.
REQ-024 In MEM, dmem_req SHALL be held at 1 until dmem_ack=1, and the block SHALL then enter WB; an ack arriving in the same cycle as the request SHALL be accepted.
REQ-025 WB SHALL last 1 cycle with wb_en=1, SHALL set pc to pc+1, and SHALL then enter FETCH.
REQ-026 The pc SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-027 HALT SHALL be absorbing: halted=1, and all strobes 0, until reset.
REQ-028 The strobes imem_req, alu_en, dmem_req and wb_en SHALL be Moore outputs and SHALL be mutually exclusive.
REQ-029 A non-halt instruction SHALL take 3+F cycles (branch), 4+F cycles (ALU), or 5+F+M cycles (memory), where F is the imem wait and M is the dmem wait.

Reset
REQ-030 When reset=1 at a rising edge, the block SHALL take precedence over all other inputs and SHALL force state=IDLE, pc=0, IR=0, with all strobes and halted at 0 from the next cycle, including mid-FETCH or mid-MEM.
REQ-031 After reset, the block SHALL require a start pulse to resume.

Structure
REQ-032 The state enum, the opcode field positions, HALT_OP and the width constants SHALL live in the shared package, alongside the datapath widths (24-bit data, 2-bit register index).
REQ-033 The block SHALL be a single module; the pc next-value adder and mux SHALL be inline, with no sub-module.

Verification
REQ-034 Scenario: reset, start=1, imem_valid=1 always, ALU instr at pc 0 -> imem_req in cycle 1, alu_en in cycle 3, wb_en in cycle 4, pc=1 in cycle 5.
REQ-035 Scenario: branch at pc=3 with offset 12'hFFE and alu_zero=0 -> pc=2; the same with alu_zero=1 -> pc=4.
REQ-036 Scenario: memory instr with dmem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles, wb_en 1 cycle later.
REQ-037 Scenario: imem_valid held low 5 cycles in FETCH -> state and pc unchanged, IR unchanged.
REQ-038 Scenario: opcode 5'b11111 fetched -> halted=1 two cycles after imem_valid, stays 1 under start pulses; reset clears it.
REQ-039 Scenario: reset asserted during MEM with dmem_req=1 -> next cycle dmem_req=0, state IDLE, pc=0; pc=4095 plus ALU instr -> pc=0.
